// File: rtl/uart_prog_loader.sv
// uart_prog_loader: parses a UART program frame (count, words, checksum) into instruction memory and replies ACK/NAK.
// Optional LOADER_ECHO_EN: echo every accepted data byte back through the transmitter.
module uart_prog_loader #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 8,
    parameter int TIMEOUT_CYCLES = 5_000_000
) (
    input  logic                  clk,
    input  logic                  arst,
    input  logic                  rx_done,
    input  logic [7:0]            rx_data,
    output logic                  tx_start,
    output logic [7:0]            tx_data,
    input  logic                  tx_done,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic                  prog_rdy,
    output logic                  load_err,
    output logic [2:0]            state
);
    localparam int BPW = DATA_WIDTH / 8;
    localparam int BW  = BPW > 1 ? $clog2(BPW) : 1;
    localparam int TW  = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [7:0] ACK = 8'h06;
    localparam logic [7:0] NAK = 8'h15;
    localparam logic [8:0] MAX_N = 9'(1 << ADDR_WIDTH);

    typedef enum logic [2:0] {IDLE = 3'd0, DATA = 3'd1, WRITE = 3'd2, CSUM = 3'd3, RESP = 3'd4} state_t;
    state_t state_q, state_d;

    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] word_q, word_d;
    logic [7:0]            csum_q, csum_d, tx_data_q, tx_data_d;
    logic [BW-1:0]         byte_idx_q, byte_idx_d;
    logic [8:0]            rem_q, rem_d;
    logic [TW-1:0]         tmo_q, tmo_d;
    logic nak_q, nak_d, sent_q, sent_d, prog_rdy_q, prog_rdy_d, load_err_q, load_err_d, tx_start_q, tx_start_d;
    logic count_ok, last_byte, tmo_hit, resp_go;

`ifdef LOADER_ECHO_EN
    logic echo_busy_q, echo_busy_d, echo_go;
    // A byte arriving while the previous echo is still in flight is simply not echoed.
    assign echo_go     = state_q == DATA && rx_done && (!echo_busy_q || tx_done);
    assign echo_busy_d = echo_go || (echo_busy_q && !tx_done);
    always_ff @(posedge clk or posedge arst)
        if (arst) echo_busy_q <= 1'b0;
        else      echo_busy_q <= echo_busy_d;
`else
    logic echo_busy_d, echo_go;
    assign echo_go     = 1'b0;
    assign echo_busy_d = 1'b0;
`endif

    assign count_ok  = rx_data != 8'd0 && {1'b0, rx_data} <= MAX_N;
    assign last_byte = byte_idx_q == BW'(BPW - 1);
    assign tmo_hit   = (state_q == DATA || state_q == CSUM) && !rx_done && tmo_q == TW'(TIMEOUT_CYCLES - 1);

    always_ff @(posedge clk or posedge arst)
        if (arst) state_q <= IDLE;
        else      state_q <= state_d;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (rx_done) state_d = count_ok ? DATA : RESP;
            DATA:    if (tmo_hit) state_d = RESP;
                     else if (rx_done && last_byte) state_d = WRITE;
            WRITE:   state_d = rem_q == 9'd1 ? CSUM : DATA;
            CSUM:    if (tmo_hit || rx_done) state_d = RESP;
            RESP:    if (sent_q && tx_done) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        addr_d     = addr_q;
        word_d     = word_q;
        csum_d     = csum_q;
        byte_idx_d = byte_idx_q;
        rem_d      = rem_q;
        nak_d      = nak_q;
        sent_d     = sent_q;
        prog_rdy_d = prog_rdy_q;
        load_err_d = load_err_q;
        tx_start_d = 1'b0;
        tx_data_d  = tx_data_q;
        tmo_d      = (state_q == DATA || state_q == CSUM) && !rx_done ? tmo_q + 1'b1 : '0;
        case (state_q)
            IDLE: if (rx_done) begin
                prog_rdy_d = 1'b0;
                nak_d      = !count_ok;
                if (count_ok) begin
                    load_err_d = 1'b0;
                    addr_d     = '0;
                    csum_d     = '0;
                    byte_idx_d = '0;
                    rem_d      = {1'b0, rx_data};
                end
            end
            DATA: if (rx_done) begin
                word_d     = (word_q << 8) | DATA_WIDTH'(rx_data);
                csum_d     = csum_q + rx_data;
                byte_idx_d = last_byte ? '0 : byte_idx_q + 1'b1;
            end else if (tmo_hit) nak_d = 1'b1;
            WRITE: begin
                addr_d = addr_q + 1'b1;
                rem_d  = rem_q - 9'd1;
            end
            CSUM: if (rx_done) nak_d = rx_data != csum_q;
                  else if (tmo_hit) nak_d = 1'b1;
            RESP: if (sent_q && tx_done) begin
                prog_rdy_d = !nak_q;
                load_err_d = nak_q;
                sent_d     = 1'b0;
            end
            default: ;
        endcase
        if (echo_go) begin
            tx_start_d = 1'b1;
            tx_data_d  = rx_data;
        end
        // The reply goes out on the first RESP cycle, or once a pending echo has completed.
        resp_go = state_d == RESP && !sent_q && !echo_busy_d;
        if (resp_go) begin
            tx_start_d = 1'b1;
            tx_data_d  = nak_d ? NAK : ACK;
            sent_d     = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge arst)
        if (arst) begin
            addr_q     <= '0;
            word_q     <= '0;
            csum_q     <= '0;
            byte_idx_q <= '0;
            rem_q      <= '0;
            tmo_q      <= '0;
            nak_q      <= 1'b0;
            sent_q     <= 1'b0;
            prog_rdy_q <= 1'b0;
            load_err_q <= 1'b0;
            tx_start_q <= 1'b0;
            tx_data_q  <= 8'h00;
        end else begin
            addr_q     <= addr_d;
            word_q     <= word_d;
            csum_q     <= csum_d;
            byte_idx_q <= byte_idx_d;
            rem_q      <= rem_d;
            tmo_q      <= tmo_d;
            nak_q      <= nak_d;
            sent_q     <= sent_d;
            prog_rdy_q <= prog_rdy_d;
            load_err_q <= load_err_d;
            tx_start_q <= tx_start_d;
            tx_data_q  <= tx_data_d;
        end

    always_comb begin
        mem_we    = state_q == WRITE;
        mem_addr  = addr_q;
        mem_wdata = word_q;
        tx_start  = tx_start_q;
        tx_data   = tx_data_q;
        prog_rdy  = prog_rdy_q;
        load_err  = load_err_q;
        state     = state_q;
    end
endmodule

// File: doc/uart_prog_loader.md
# uart_prog_loader

Program-load sequencer between the UART receiver/transmitter pair and the processor instruction memory. It takes bytes from the receiver and parses a framed program image (word count, data words, checksum). It writes each assembled word to instruction memory and answers the host with ACK/NAK through the transmitter. `prog_rdy` is raised only after a verified image.

## Interface
- `DATA_WIDTH`, 32: instruction word width; multiple of 8.
- `ADDR_WIDTH`, 8: instruction memory address width; 1..8.
- `TIMEOUT_CYCLES`, 5_000_000: maximum number of idle clocks between bytes during a load.

- `clk`  in  1  system clock, rising edge.
- `arst`  in  1  asynchronous active-high reset.
- `rx_done`  in  1  one-cycle pulse; `rx_data` valid.
- `rx_data`  in  8  received byte.
- `tx_start`  out  1  one-cycle pulse requesting transmission of `tx_data`.
- `tx_data`  out  8  byte to transmit; held stable until `tx_done`.
- `tx_done`  in  1  one-cycle pulse; transmitter finished the byte.
- `mem_we`  out  1  instruction memory write strobe.
- `mem_addr`  out  ADDR_WIDTH  write address.
- `mem_wdata`  out  DATA_WIDTH  write data.
- `prog_rdy`  out  1  level; a valid program is loaded.
- `load_err`  out  1  level; the last load failed.
- `state`  out  3  current FSM state, for debug.

## Operation
- Frame: count byte N, then N words of DATA_WIDTH/8 bytes each (MSB first), then checksum byte. Checksum is the sum mod 256 of all data bytes; the count byte is excluded.
- States:
  - IDLE=0: on `rx_done`, take N from `rx_data`. If N==0 or N>2^ADDR_WIDTH, go to RESP with NAK. Otherwise clear `prog_rdy` and `load_err`, zero address/checksum/byte index, and go to DATA.
  - DATA=1: on each `rx_done`, shift the byte into the word register and add it to the checksum. After byte DATA_WIDTH/8-1, go to WRITE.
  - WRITE=2: assert `mem_we` for exactly one cycle. Then increment the address and decrement the remaining-word count. Go to CSUM when the last word is written, else back to DATA.
  - CSUM=3: on `rx_done`, compare the byte with the accumulated checksum. Go to RESP with ACK (0x06) on match, NAK (0x15) otherwise.
  - RESP=4: pulse `tx_start` once with `tx_data` = ACK/NAK, then wait for `tx_done`. ACK sets `prog_rdy`=1; NAK sets `load_err`=1. Return to IDLE.
- Timeout: in DATA or CSUM, a counter increments every clock without `rx_done` and clears on `rx_done`. Reaching TIMEOUT_CYCLES sends the FSM to RESP with NAK. The partial image is left in memory and `prog_rdy` stays 0.
- `rx_done` in WRITE or RESP is ignored. The byte is dropped and the frame desynchronises; the host recovers through timeout/NAK.
- A new count byte in IDLE while `prog_rdy`=1 starts a reload and clears `prog_rdy` immediately.
- Address wrap: not possible; N is bounded by 2^ADDR_WIDTH.

## Timing
- Reset values: `state`=IDLE, `tx_start`=0, `tx_data`=0x00, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0, `prog_rdy`=0, `load_err`=0, timeout counter 0.
- `mem_we` is high on the cycle after the `rx_done` of the last byte of the word. `mem_addr` equals the word index and `mem_wdata` the assembled word on that cycle.
- `tx_start` is high on the cycle after entering RESP.
- `prog_rdy`/`load_err` update on the cycle after `tx_done`, together with the IDLE transition.
- `arst` mid-load aborts immediately to reset values; no response is sent.

## Configuration
- `LOADER_ECHO_EN` defined: every data byte accepted in DATA is echoed through `tx_start`/`tx_data`.
  - If an echo is still in flight when the next byte arrives, that echo is dropped; load behaviour is unaffected.
  - RESP waits for any in-flight echo's `tx_done` before issuing ACK/NAK.
- `LOADER_ECHO_EN` undefined: `tx_start` pulses only in RESP.

## Test plan
- DATA_WIDTH=32. Send N=2, bytes 11 22 33 44 AA BB CC DD, checksum 0xB8 -> writes addr0=0x11223344 and addr1=0xAABBCCDD; `tx_data`=0x06; `prog_rdy`=1; `load_err`=0.
- Same frame with checksum 0xB9 -> both writes occur; NAK 0x15 sent; `prog_rdy`=0; `load_err`=1.
- Count byte 0x00 -> no `mem_we`; NAK 0x15 sent; `load_err`=1; state returns to 0.
- TIMEOUT_CYCLES=100. Send N=1 and two data bytes, then stop -> NAK 0x15 is sent 100 cycles after the last `rx_done`; `load_err`=1.
- Successful load, then send count byte 0x01 -> `prog_rdy` drops the cycle after that `rx_done`. A good frame restores it.
- `arst` pulsed during DATA -> all outputs return to reset values. A following good frame loads normally from addr0.
